// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix entry loader.
//   DIM            rows = cols of each operand matrix
//   WIDTH          element width, matches the keypad encoder keycode
//   NELEM          elements per operand
//   IDX_W          width of the element index, which runs 0..NELEM
//   loader_state_t operand-loading sequence states
//   elem_t         one matrix element
package matrix_pkg;

    localparam int DIM   = 3;
    localparam int WIDTH = 9;
    localparam int NELEM = DIM * DIM;
    localparam int IDX_W = $clog2(NELEM + 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ISSUE  = 2'd2
    } loader_state_t;

    typedef logic [WIDTH-1:0] elem_t;

endpackage

// File: rtl/matrix_operand_reg.sv
// DIM*DIM x WIDTH operand register file, flat-packed with element k at
// [k*WIDTH +: WIDTH].
//   clk      system clock
//   nrst     asynchronous active-low reset, clears every element
//   i_we     write enable for the element selected by i_idx
//   i_idx    element index; values >= DIM*DIM never write
//   i_wdata  element write data
//   i_clr    synchronous clear of every element, takes priority over a write
//   o_mat    packed register contents
module matrix_operand_reg #(
    parameter int DIM   = matrix_pkg::DIM,
    parameter int WIDTH = matrix_pkg::WIDTH
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            i_we,
    input  logic [$clog2(DIM*DIM+1)-1:0]    i_idx,
    input  logic [WIDTH-1:0]                i_wdata,
    input  logic                            i_clr,
    output logic [DIM*DIM*WIDTH-1:0]        o_mat
);

    localparam int NELEM = DIM * DIM;
    localparam int IDX_W = $clog2(NELEM + 1);

    logic [NELEM*WIDTH-1:0] r_mem;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mem <= '0;
        end else if (i_clr) begin
            r_mem <= '0;
        end else if (i_we) begin
            for (int k = 0; k < NELEM; k++) begin
                if (i_idx == IDX_W'(k)) begin
                    r_mem[k*WIDTH +: WIDTH] <= i_wdata;
                end
            end
        end
    end

    assign o_mat = r_mem;

endmodule

// File: rtl/matrix_entry_loader.sv
// Matrix entry loader: fills operand A then operand B from keypad keycodes in
// row-major order and offers both to the matrix ALU with a valid/ready
// handshake.
//   clk           system clock
//   nrst          asynchronous active-low reset
//   keycode       encoder keycode, sampled when store_dig=1
//   store_dig     write keycode into the current element
//   enter         close operand A (ignored elsewhere)
//   result_ready  close operand B and offer operands to the ALU
//   alu_ready     ALU accepts operands
//   mat_a, mat_b  packed operands, element k at [k*WIDTH +: WIDTH]
//   mat_valid     operands stable and offered
//   sel_b         0 = filling A, 1 = filling B
//   elem_idx      next element index, saturates at DIM*DIM
//   ovf           one-cycle pulse when a store_dig was dropped
//
// state  | meaning
// LOAD_A | writing operand A elements
// LOAD_B | writing operand B elements
// ISSUE  | operands frozen; mat_valid raised one cycle after entry, held until alu_ready
module matrix_entry_loader #(
    parameter int DIM   = matrix_pkg::DIM,
    parameter int WIDTH = matrix_pkg::WIDTH
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [WIDTH-1:0]                keycode,
    input  logic                            store_dig,
    input  logic                            enter,
    input  logic                            result_ready,
    input  logic                            alu_ready,
    output logic [DIM*DIM*WIDTH-1:0]        mat_a,
    output logic [DIM*DIM*WIDTH-1:0]        mat_b,
    output logic                            mat_valid,
    output logic                            sel_b,
    output logic [$clog2(DIM*DIM+1)-1:0]    elem_idx,
    output logic                            ovf
);

    import matrix_pkg::*;

    localparam int                  NELEM_L  = DIM * DIM;
    localparam int                  IDX_W_L  = $clog2(NELEM_L + 1);
    localparam logic [IDX_W_L-1:0]  IDX_FULL = IDX_W_L'(NELEM_L);

    loader_state_t          r_state;
    logic [IDX_W_L-1:0]     r_idx;
    logic                   r_sel_b;
    logic                   r_valid;
    logic                   r_ovf;

    logic                   w_store_ok;
    logic                   w_we_a;
    logic                   w_we_b;
    logic                   w_accept;

    // A store lands only while loading and while the operand still has room.
    assign w_store_ok = store_dig && (r_state != ISSUE) && (r_idx != IDX_FULL);
    assign w_we_a     = w_store_ok && (r_state == LOAD_A);
    assign w_we_b     = w_store_ok && (r_state == LOAD_B);
    assign w_accept   = (r_state == ISSUE) && r_valid && alu_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= LOAD_A;
            r_idx   <= '0;
            r_sel_b <= 1'b0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= store_dig && !w_store_ok;
            case (r_state)
                LOAD_A: begin
                    // A store in the same cycle as enter still lands in A.
                    if (enter) begin
                        r_state <= LOAD_B;
                        r_idx   <= '0;
                        r_sel_b <= 1'b1;
                    end else if (w_store_ok) begin
                        r_idx <= r_idx + IDX_W_L'(1);
                    end
                end
                LOAD_B: begin
                    if (w_store_ok) begin
                        r_idx <= r_idx + IDX_W_L'(1);
                    end
                    if (result_ready) begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_accept) begin
                        r_state <= LOAD_A;
                        r_idx   <= '0;
                        r_sel_b <= 1'b0;
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                    r_idx   <= '0;
                    r_sel_b <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    matrix_operand_reg #(.DIM(DIM), .WIDTH(WIDTH)) u_reg_a (
        .clk     (clk),
        .nrst    (nrst),
        .i_we    (w_we_a),
        .i_idx   (r_idx),
        .i_wdata (keycode),
        .i_clr   (w_accept),
        .o_mat   (mat_a)
    );

    matrix_operand_reg #(.DIM(DIM), .WIDTH(WIDTH)) u_reg_b (
        .clk     (clk),
        .nrst    (nrst),
        .i_we    (w_we_b),
        .i_idx   (r_idx),
        .i_wdata (keycode),
        .i_clr   (w_accept),
        .o_mat   (mat_b)
    );

    assign mat_valid = r_valid;
    assign sel_b     = r_sel_b;
    assign elem_idx  = r_idx;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_matrix_entry_loader.sv
module tb_matrix_entry_loader;

    logic        clk = 1'b0;
    logic        nrst;
    logic [8:0]  keycode;
    logic        store_dig;
    logic        enter;
    logic        result_ready;
    logic        alu_ready;
    logic [80:0] mat_a;
    logic [80:0] mat_b;
    logic        mat_valid;
    logic        sel_b;
    logic [3:0]  elem_idx;
    logic        ovf;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain arrays and a phase number (0 = A, 1 = B, 2 = offered).
    int m_a [9];
    int m_b [9];
    int m_phase;
    int m_idx;
    bit m_valid;
    bit m_selb;
    bit m_ovf;

    matrix_entry_loader dut (
        .clk          (clk),
        .nrst         (nrst),
        .keycode      (keycode),
        .store_dig    (store_dig),
        .enter        (enter),
        .result_ready (result_ready),
        .alu_ready    (alu_ready),
        .mat_a        (mat_a),
        .mat_b        (mat_b),
        .mat_valid    (mat_valid),
        .sel_b        (sel_b),
        .elem_idx     (elem_idx),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [80:0] pack9(input int arr [9]);
        logic [80:0] p;
        p = '0;
        for (int k = 0; k < 9; k++) p[k*9 +: 9] = arr[k][8:0];
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) begin
            m_a[k] = 0;
            m_b[k] = 0;
        end
        m_phase = 0;
        m_idx   = 0;
        m_valid = 1'b0;
        m_selb  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input bit st, input int key, input bit en, input bit rr, input bit ar);
        bit room;
        room  = (m_phase < 2) && (m_idx < 9);
        m_ovf = st && !room;
        if (m_phase == 0) begin
            if (st && room) begin
                m_a[m_idx] = key;
                m_idx = m_idx + 1;
            end
            if (en) begin
                m_phase = 1;
                m_idx   = 0;
                m_selb  = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (st && room) begin
                m_b[m_idx] = key;
                m_idx = m_idx + 1;
            end
            if (rr) m_phase = 2;
        end else begin
            if (m_valid && ar) begin
                for (int k = 0; k < 9; k++) begin
                    m_a[k] = 0;
                    m_b[k] = 0;
                end
                m_phase = 0;
                m_idx   = 0;
                m_selb  = 1'b0;
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [80:0] obs, input logic [80:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, "/mat_a"},     mat_a,            pack9(m_a));
        check({ctx, "/mat_b"},     mat_b,            pack9(m_b));
        check({ctx, "/mat_valid"}, 81'(mat_valid),   81'(m_valid));
        check({ctx, "/sel_b"},     81'(sel_b),       81'(m_selb));
        check({ctx, "/elem_idx"},  81'(elem_idx),    81'(m_idx));
        check({ctx, "/ovf"},       81'(ovf),         81'(m_ovf));
    endtask

    // One clock with the given inputs; model advances on the same edge.
    task automatic step(input bit st, input int key, input bit en, input bit rr, input bit ar, input string ctx);
        store_dig    = st;
        keycode      = key[8:0];
        enter        = en;
        result_ready = rr;
        alu_ready    = ar;
        @(posedge clk);
        model_step(st, key, en, rr, ar);
        #1;
        check_all(ctx);
    endtask

    initial begin
        logic [80:0] exp_a;
        nrst = 1'b0; keycode = 9'd5; store_dig = 1'b1;
        enter = 1'b0; result_ready = 1'b0; alu_ready = 1'b0;

        // Reset held while store_dig pulses: nothing may be written.
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        store_dig = 1'b0;
        nrst = 1'b1;
        step(0, 0, 0, 0, 0, "idle");

        // Fill A with 1..9, then one extra store which must overflow.
        for (int k = 1; k <= 9; k++) step(1, k, 0, 0, 1, "fill_a");
        step(1, 9'h55, 0, 0, 0, "ovf_a");
        check("ovf_a_pulse", 81'(ovf), 81'(1));
        step(0, 0, 1, 0, 0, "enter_a");
        exp_a = '0;
        for (int k = 0; k < 9; k++) exp_a[k*9 +: 9] = 9'(k + 1);
        check("fill_a_const", mat_a, exp_a);
        check("sel_b_after_enter", 81'(sel_b), 81'(1));
        check("idx_after_enter", 81'(elem_idx), 81'(0));

        // Partial B, then request computation.
        step(1, 9'h1FF, 0, 0, 0, "part_b");
        step(1, 9'h1FF, 0, 0, 0, "part_b");
        step(0, 0, 0, 1, 0, "issue_enter");
        check("valid_not_yet", 81'(mat_valid), 81'(0));
        step(0, 0, 0, 0, 0, "issue_valid");
        check("valid_raised", 81'(mat_valid), 81'(1));
        check("part_b_const", mat_b, {63'd0, 9'h1FF, 9'h1FF});

        // Backpressure with a dropped store in the middle.
        for (int c = 0; c < 5; c++) step(c == 2, 9'h077, c == 3, c == 4, 0, "backpressure");
        step(0, 0, 0, 0, 1, "accept");
        check("accept_valid", 81'(mat_valid), 81'(0));
        check("accept_mat_a", mat_a, 81'(0));

        // Simultaneous store with enter, then store with result_ready.
        step(1, 9'h0AA, 1, 0, 0, "simul_enter");
        check("simul_a0", 81'(mat_a[8:0]), 81'(9'h0AA));
        step(1, 9'h133, 0, 1, 0, "simul_rr");
        check("simul_b0", 81'(mat_b[8:0]), 81'(9'h133));
        step(0, 0, 0, 0, 0, "simul_valid");
        step(0, 0, 0, 0, 1, "simul_accept");

        // Reset in the middle of filling B.
        step(1, 9'h011, 0, 0, 0, "pre_rst_a");
        step(0, 0, 1, 0, 0, "pre_rst_enter");
        for (int k = 0; k < 4; k++) step(1, 9'h100 + k, 0, 0, 0, "pre_rst_b");
        nrst = 1'b0;
        #2;
        model_reset();
        check_all("reset_mid");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        step(0, 0, 0, 0, 0, "post_rst");

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 511)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
